amm_demux_pipelined: RTL and testbench
======================================

Name: amm_demux_pipelined

Overview:
Parametrised Avalon-MM 1-to-N address demultiplexer with pipelined-read support. It sits between one Avalon-MM master (the JTAG bridge) and SLV_CNT slaves. It decodes base/span windows, forwards commands with a local offset address, and tracks outstanding reads in an in-order FIFO so each readdatavalid is returned from the correct slave. Unmapped accesses go to an internal default slave, which answers with a fixed pattern and flags a decode error.

Parameters:
SLV_CNT, 4, number of slave ports (1..16)
ADDR_W, 32, address width
DATA_W, 16, data width
SLV_BASE, {0x0000,0x1000,0x2000,0x3000}, per-slave base address, array [SLV_CNT] of ADDR_W
SLV_SPAN, {0x1000,0x1000,0x1000,0x1000}, per-slave window size in words, array [SLV_CNT] of ADDR_W
MAX_PEND, 4, maximum outstanding reads (power of 2, 1..16)
DEFAULT_DATA, 16'hBEAF, readdata returned for unmapped reads (zero-extended or truncated to DATA_W)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
mst_address_i  in  ADDR_W  master address
mst_read_i  in  1  master read request
mst_write_i  in  1  master write request
mst_writedata_i  in  DATA_W  master write data
mst_waitrequest_o  out  1  stall to master
mst_readdata_o  out  DATA_W  read data to master
mst_readdatavalid_o  out  1  read data valid to master
slv_address_o  out  SLV_CNT*ADDR_W  per-slave local address (addr - SLV_BASE[i])
slv_read_o  out  SLV_CNT  per-slave read
slv_write_o  out  SLV_CNT  per-slave write
slv_writedata_o  out  SLV_CNT*DATA_W  per-slave write data (broadcast)
slv_waitrequest_i  in  SLV_CNT  per-slave stall
slv_readdata_i  in  SLV_CNT*DATA_W  per-slave read data
slv_readdatavalid_i  in  SLV_CNT  per-slave read valid
decode_err_o  out  1  one-cycle pulse on an accepted access to an unmapped address
unexp_rdv_o  out  1  sticky: readdatavalid seen from a slave not at the FIFO head; cleared by reset only
pend_cnt_o  out  $clog2(MAX_PEND+1)  current outstanding read count

Behaviour:
- Decode (combinational): sel = lowest i with SLV_BASE[i] <= addr < SLV_BASE[i]+SLV_SPAN[i]. If no window matches, sel = DEF (SLV_CNT). Overlapping windows resolve to the lowest index.
- block = (read & pend_cnt==MAX_PEND) | ((read|write) & pend_cnt!=0 & sel!=tail_sel). tail_sel is the slave index of the most recently pushed read. This keeps responses in order.
- Forwarding: slv_read_o[i] = mst_read_i & sel==i & ~block; slv_write_o is formed the same way. Address and writedata go to all slaves.
- mst_waitrequest_o:
  - 1 if block;
  - else 0 if sel==DEF;
  - else slv_waitrequest_i[sel].
- Acceptance: an access is accepted on a cycle with (read|write) & ~mst_waitrequest_o. An accepted read pushes sel into the pending FIFO, depth MAX_PEND.
- Default slave:
  - An accepted unmapped read asserts def_rdv one cycle later, with readdata = DEFAULT_DATA.
  - An accepted unmapped write is dropped.
  - Both pulse decode_err_o in the cycle after acceptance.
- Response path:
  - head = FIFO head index.
  - mst_readdatavalid_o = pend_cnt!=0 & (head==DEF ? def_rdv : slv_readdatavalid_i[head]).
  - mst_readdata_o follows the head source when valid, else 0.
  - Pop when mst_readdatavalid_o is high.
  - slv_readdatavalid_i[j] with j!=head, or any slave rdv while pend_cnt==0, sets unexp_rdv_o and is discarded.
- Push and pop in the same cycle: pend_cnt unchanged, pointers both advance. Pointers wrap modulo MAX_PEND.
- Writes never enter the FIFO. A write to the same slave as pending reads passes; a write to a different slave stalls until pend_cnt==0.
- Reset (rst_i high at a clock edge):
  - FIFO pointers, pend_cnt, def_rdv, decode_err_o and unexp_rdv_o clear to 0.
  - While rst_i is high: slv_read_o/slv_write_o = 0 and mst_waitrequest_o = 1.
  - Reset mid-transaction discards pending reads; late slave responses after reset set unexp_rdv_o.
- Latency: zero added on the command path. Slave read latency passes straight through. The default slave has a fixed 1-cycle read latency.

Test Plan:
- Mapped read: addr 0x1005, slave1 rdv 3 cycles later with data 0x1234 -> slv_read_o=4'b0010, slv_address_o[1]=0x0005, mst_readdatavalid_o pulses once with 0x1234, pend_cnt returns 0.
- Unmapped read: addr 0x9000 -> waitrequest 0, next cycle mst_readdatavalid_o=1 with 0xBEAF, decode_err_o pulses one cycle, no slv_read_o asserted.
- Pipelined limit: slave2 never waits and never responds, 5 back-to-back reads -> 4 accepted, pend_cnt=4, 5th held by waitrequest until one response pops.
- Ordering stall: 2 pending reads to slave0, then read to slave3 -> waitrequest high and slv_read_o[3]=0 until both slave0 responses return, then accepted the next cycle.
- Unexpected response: slave2 rdv while head=slave0 -> unexp_rdv_o=1 and stays 1, mst_readdatavalid_o=0, pend_cnt unchanged.
- Reset mid-flight: 3 pending reads, assert rst_i one cycle -> pend_cnt=0, outputs at reset values, a subsequent read to slave1 completes normally.

Source files
------------

// File: rtl/amm_demux_pipelined_if.sv
// Avalon-MM master-side bus bundle feeding the demux.
interface amm_demux_pipelined_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/amm_demux_pipelined.sv
// Avalon-MM 1-to-N demux with in-order pipelined read tracking.
module amm_demux_pipelined #(
  parameter int SLV_CNT = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 16,
  parameter logic [SLV_CNT-1:0][ADDR_W-1:0] SLV_BASE =
    {32'h3000, 32'h2000, 32'h1000, 32'h0000},
  parameter logic [SLV_CNT-1:0][ADDR_W-1:0] SLV_SPAN =
    {32'h1000, 32'h1000, 32'h1000, 32'h1000},
  parameter int MAX_PEND = 4,
  parameter logic [15:0] DEFAULT_DATA = 16'hBEAF
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  amm_demux_pipelined_if.slave         mst,
  output logic [SLV_CNT*ADDR_W-1:0]    slv_address_o,
  output logic [SLV_CNT-1:0]           slv_read_o,
  output logic [SLV_CNT-1:0]           slv_write_o,
  output logic [SLV_CNT*DATA_W-1:0]    slv_writedata_o,
  input  logic [SLV_CNT-1:0]           slv_waitrequest_i,
  input  logic [SLV_CNT*DATA_W-1:0]    slv_readdata_i,
  input  logic [SLV_CNT-1:0]           slv_readdatavalid_i,
  output logic                         decode_err_o,
  output logic                         unexp_rdv_o,
  output logic [$clog2(MAX_PEND+1)-1:0] pend_cnt_o
);
  localparam int SW = $clog2(SLV_CNT + 1);
  localparam int PW = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
  localparam int CW = $clog2(MAX_PEND + 1);
  localparam logic [SW-1:0] DEF  = SW'(SLV_CNT);
  localparam logic [CW-1:0] FULL = CW'(MAX_PEND);
  localparam logic [DATA_W-1:0] DEF_DATA = DATA_W'(DEFAULT_DATA);

  logic [SW-1:0] sel;
  logic [SW-1:0] tail_sel;
  logic [SW-1:0] head;
  logic [SW-1:0] fifo [MAX_PEND];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          def_rdv;
  logic          dec_err;
  logic          unexp;
  logic          req;
  logic          blk;
  logic          wait_r;
  logic          sel_wait;
  logic          acc;
  logic          push;
  logic          rdv;
  logic          stray;
  logic [DATA_W-1:0] rdata;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(MAX_PEND - 1)) ? '0 : p + 1'b1;
  endfunction

  // Descending scan so the lowest matching window wins.
  always_comb begin
    sel = DEF;
    for (int i = SLV_CNT - 1; i >= 0; i--) begin
      if (mst.address >= SLV_BASE[i] &&
          (mst.address - SLV_BASE[i]) < SLV_SPAN[i])
        sel = SW'(i);
    end
  end

  assign req = mst.read | mst.write;
  assign blk = (mst.read & (cnt == FULL)) |
               (req & (cnt != '0) & (sel != tail_sel));

  always_comb begin
    sel_wait = 1'b0;
    for (int i = 0; i < SLV_CNT; i++)
      if (sel == SW'(i)) sel_wait = slv_waitrequest_i[i];
  end

  always_comb begin
    if (rst_i || blk)    wait_r = 1'b1;
    else if (sel == DEF) wait_r = 1'b0;
    else                 wait_r = sel_wait;
  end

  assign mst.waitrequest = wait_r;
  assign acc  = req & ~wait_r;
  assign push = acc & mst.read;

  always_comb begin
    slv_read_o    = '0;
    slv_write_o   = '0;
    slv_address_o = '0;
    for (int i = 0; i < SLV_CNT; i++) begin
      slv_read_o[i]  = mst.read & (sel == SW'(i)) & ~blk & ~rst_i;
      slv_write_o[i] = mst.write & (sel == SW'(i)) & ~blk & ~rst_i;
      slv_address_o[i*ADDR_W +: ADDR_W] = mst.address - SLV_BASE[i];
    end
  end

  assign slv_writedata_o = {SLV_CNT{mst.writedata}};
  assign head = fifo[rd_ptr];

  // Only the FIFO head may answer; anything else is stray.
  always_comb begin
    rdv   = 1'b0;
    rdata = '0;
    stray = 1'b0;
    if (cnt != '0 && head == DEF && def_rdv) begin
      rdv   = 1'b1;
      rdata = DEF_DATA;
    end
    for (int i = 0; i < SLV_CNT; i++) begin
      if (slv_readdatavalid_i[i]) begin
        if (cnt != '0 && head == SW'(i)) begin
          rdv   = 1'b1;
          rdata = slv_readdata_i[i*DATA_W +: DATA_W];
        end else begin
          stray = 1'b1;
        end
      end
    end
  end

  assign mst.readdatavalid = rdv;
  assign mst.readdata      = rdata;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      tail_sel <= '0;
      def_rdv  <= 1'b0;
      dec_err  <= 1'b0;
      unexp    <= 1'b0;
    end else begin
      def_rdv <= push & (sel == DEF);
      dec_err <= acc & (sel == DEF);
      if (stray) unexp <= 1'b1;
      if (push) begin
        fifo[wr_ptr] <= sel;
        tail_sel     <= sel;
        wr_ptr       <= nxt(wr_ptr);
      end
      if (rdv) rd_ptr <= nxt(rd_ptr);
      unique case ({push, rdv})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign decode_err_o = dec_err;
  assign unexp_rdv_o  = unexp;
  assign pend_cnt_o   = cnt;
endmodule

// File: tb/tb_amm_demux_pipelined.sv
// Randomised + directed bench for amm_demux_pipelined.
module tb_amm_demux_pipelined;
  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 16;
  localparam int MP  = 4;
  localparam int DEF = N;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  amm_demux_pipelined_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  logic [N*AW-1:0] s_addr;
  logic [N-1:0]    s_rd;
  logic [N-1:0]    s_wr;
  logic [N*DW-1:0] s_wd;
  logic [N-1:0]    s_wait = '0;
  logic [N*DW-1:0] s_rdata = '0;
  logic [N-1:0]    s_rdv = '0;
  logic            derr;
  logic            unexp;
  logic [2:0]      pcnt;

  amm_demux_pipelined dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .mst                 (bus),
    .slv_address_o       (s_addr),
    .slv_read_o          (s_rd),
    .slv_write_o         (s_wr),
    .slv_writedata_o     (s_wd),
    .slv_waitrequest_i   (s_wait),
    .slv_readdata_i      (s_rdata),
    .slv_readdatavalid_i (s_rdv),
    .decode_err_o        (derr),
    .unexp_rdv_o         (unexp),
    .pend_cnt_o          (pcnt)
  );

  int unsigned base [N] = '{32'h0000, 32'h1000, 32'h2000, 32'h3000};
  int unsigned span [N] = '{32'h1000, 32'h1000, 32'h1000, 32'h1000};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int decode(logic [31:0] a);
    for (int i = 0; i < N; i++)
      if (longint'(a) >= longint'(base[i]) &&
          longint'(a) < longint'(base[i]) + longint'(span[i]))
        return i;
    return DEF;
  endfunction

  function automatic logic [15:0] sdat(int s, logic [31:0] off);
    return off[15:0] ^ 16'(s << 12) ^ 16'h0231;
  endfunction

  // Slave-side environment: in-order responses per slave.
  typedef struct { int s; int due; logic [15:0] d; } rsp_t;
  rsp_t sq [$];
  int lat [N] = '{1, 1, 1, 1};
  int last_due [N] = '{0, 0, 0, 0};
  logic [N-1:0] hold = '0;
  logic [N-1:0] inj = '0;
  bit rnd_lat = 0;
  int cyc = 0;

  // Reference: queue of expected master responses, in issue order.
  typedef struct { int s; logic [15:0] d; } exp_t;
  exp_t eq [$];
  int tail_m = 0;
  bit def_p = 0, derr_m = 0, unexp_m = 0;
  bit last_acc = 0;

  logic         sn_wait, sn_rdv, sn_derr, sn_unexp;
  logic [N-1:0] sn_rd;
  logic [15:0]  sn_data;
  logic [2:0]   sn_pcnt;
  logic [31:0]  sn_addr1;

  task automatic step();
    int sel, hd, l;
    bit blk, ew, acc, erdv, stray;
    logic [15:0] ed;
    logic [N-1:0] erd, ewr;
    logic [31:0] off;
    s_rdv = '0;
    s_rdata = '0;
    for (int i = 0; i < N; i++) begin
      if (inj[i]) begin
        s_rdv[i] = 1'b1;
        s_rdata[i*DW +: DW] = 16'hDEAD;
      end else if (!hold[i]) begin
        for (int j = 0; j < sq.size(); j++) begin
          if (sq[j].s == i) begin
            if (sq[j].due <= cyc) begin
              s_rdv[i] = 1'b1;
              s_rdata[i*DW +: DW] = sq[j].d;
              sq.delete(j);
            end
            break;
          end
        end
      end
    end
    #3;
    sel = decode(bus.address);
    blk = (bus.read && eq.size() == MP) ||
          ((bus.read || bus.write) && eq.size() != 0 && sel != tail_m);
    ew = rst || blk;
    if (!ew && sel != DEF) ew = s_wait[sel];
    acc = (bus.read || bus.write) && !ew;
    erd = '0;
    ewr = '0;
    if (!rst && !blk && sel != DEF) begin
      erd[sel] = bus.read;
      ewr[sel] = bus.write;
    end
    hd = (eq.size() != 0) ? eq[0].s : -1;
    erdv = 0;
    if (hd == DEF) erdv = def_p;
    else if (hd >= 0) erdv = s_rdv[hd];
    ed = erdv ? eq[0].d : 16'h0;
    stray = 0;
    for (int i = 0; i < N; i++)
      if (s_rdv[i] && i != hd) stray = 1;
    check("waitrequest", bus.waitrequest, ew);
    check("slv_read", s_rd, erd);
    check("slv_write", s_wr, ewr);
    check("readdatavalid", bus.readdatavalid, erdv);
    check("readdata", bus.readdata, ed);
    check("pend_cnt", pcnt, eq.size());
    check("decode_err", derr, derr_m);
    check("unexp_rdv", unexp, unexp_m);
    check("wdata_bcast", s_wd[(N-1)*DW +: DW], bus.writedata);
    if (sel != DEF) begin
      off = bus.address - base[sel];
      check("slv_addr", s_addr[sel*AW +: AW], off);
    end
    sn_wait = bus.waitrequest;
    sn_rd = s_rd;
    sn_rdv = bus.readdatavalid;
    sn_data = bus.readdata;
    sn_derr = derr;
    sn_unexp = unexp;
    sn_pcnt = pcnt;
    sn_addr1 = s_addr[AW +: AW];
    for (int i = 0; i < N; i++) begin
      if (s_rd[i] && !s_wait[i]) begin
        l = rnd_lat ? int'($urandom_range(1, 4)) : lat[i];
        l = cyc + l;
        if (l <= last_due[i]) l = last_due[i] + 1;
        last_due[i] = l;
        sq.push_back('{i, l, sdat(i, s_addr[i*AW +: AW])});
      end
    end
    if (rst) begin
      eq.delete();
      def_p = 0;
      derr_m = 0;
      unexp_m = 0;
    end else begin
      if (erdv) void'(eq.pop_front());
      if (acc && bus.read) begin
        off = (sel == DEF) ? 32'h0 : bus.address - base[sel];
        eq.push_back('{sel, (sel == DEF) ? 16'hBEAF : sdat(sel, off)});
        tail_m = sel;
      end
      def_p = acc && bus.read && sel == DEF;
      derr_m = acc && sel == DEF;
      if (stray) unexp_m = 1;
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    bus.read = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic issue(bit rd, logic [31:0] a);
    bit ok = 0;
    bus.read = rd;
    bus.write = !rd;
    bus.address = a;
    bus.writedata = 16'($urandom);
    for (int k = 0; k < 20 && !ok; k++) begin
      step();
      ok = last_acc;
    end
    idle();
    check("issue_accepted", ok, 1);
  endtask

  task automatic drain(string tag);
    idle();
    for (int k = 0; k < 20; k++) step();
    check(tag, sn_pcnt, 0);
  endtask

  int nacc, nrdv;
  logic [15:0] got_d;
  bit pend;
  int r;

  initial begin
    idle();
    bus.address = '0;
    bus.writedata = '0;
    @(posedge clk);
    #1;
    // reset state while a read is presented
    bus.read = 1'b1;
    bus.address = 32'h1000;
    step();
    check("rst_wait", sn_wait, 1);
    check("rst_slv_rd", sn_rd, 0);
    rst = 1'b0;
    idle();
    step();
    check("rst_pend", sn_pcnt, 0);
    check("rst_unexp", sn_unexp, 0);

    // mapped read, 3-cycle slave latency
    lat[1] = 3;
    bus.read = 1'b1;
    bus.address = 32'h1005;
    step();
    check("t1_slv_rd", sn_rd, 4'b0010);
    check("t1_addr1", sn_addr1, 32'h5);
    idle();
    nrdv = 0;
    got_d = '0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (sn_rdv) begin
        nrdv++;
        got_d = sn_data;
      end
    end
    check("t1_rdv_cnt", nrdv, 1);
    check("t1_data", got_d, 16'h1234);
    check("t1_pend", sn_pcnt, 0);
    lat[1] = 1;

    // unmapped read
    bus.read = 1'b1;
    bus.address = 32'h9000;
    step();
    check("t2_wait", sn_wait, 0);
    check("t2_slv_rd", sn_rd, 0);
    idle();
    step();
    check("t2_rdv", sn_rdv, 1);
    check("t2_data", sn_data, 16'hBEAF);
    check("t2_derr", sn_derr, 1);
    step();
    check("t2_derr_off", sn_derr, 0);

    // pipelined limit on a silent slave2
    hold[2] = 1'b1;
    nacc = 0;
    for (int k = 0; k < 5; k++) begin
      bus.read = 1'b1;
      bus.address = 32'h2000 + nacc;
      step();
      if (!sn_wait) nacc++;
    end
    check("t3_accepted", nacc, 4);
    check("t3_pend_full", sn_pcnt, 4);
    check("t3_wait_full", sn_wait, 1);
    hold[2] = 1'b0;
    step();
    check("t3_pop_rdv", sn_rdv, 1);
    check("t3_still_wait", sn_wait, 1);
    step();
    check("t3_fifth_acc", sn_wait, 0);
    drain("t3_drain");

    // ordering stall: slave0 pending, then slave3
    hold[0] = 1'b1;
    issue(1, 32'h0010);
    issue(1, 32'h0020);
    bus.read = 1'b1;
    bus.address = 32'h3000;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t4_wait", sn_wait, 1);
      check("t4_rd3", sn_rd[3], 0);
    end
    hold[0] = 1'b0;
    nrdv = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (sn_rdv) nrdv++;
      if (!sn_wait) break;
    end
    check("t4_rdv_before", nrdv, 2);
    check("t4_rd_acc", sn_rd, 4'b1000);
    drain("t4_drain");

    // unexpected response from slave2 while head is slave0
    hold[0] = 1'b1;
    issue(1, 32'h0040);
    inj[2] = 1'b1;
    step();
    check("t5_rdv", sn_rdv, 0);
    inj[2] = 1'b0;
    step();
    check("t5_unexp", sn_unexp, 1);
    check("t5_pend", sn_pcnt, 1);
    hold[0] = 1'b0;
    drain("t5_drain");
    check("t5_sticky", sn_unexp, 1);

    // reset with three reads in flight
    hold[1] = 1'b1;
    issue(1, 32'h1001);
    issue(1, 32'h1002);
    issue(1, 32'h1003);
    rst = 1'b1;
    bus.read = 1'b1;
    bus.address = 32'h1010;
    step();
    check("t6_rst_wait", sn_wait, 1);
    check("t6_rst_rd", sn_rd, 0);
    rst = 1'b0;
    idle();
    step();
    check("t6_pend", sn_pcnt, 0);
    check("t6_unexp_clr", sn_unexp, 0);
    hold[1] = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("t6_late_unexp", sn_unexp, 1);
    issue(1, 32'h1100);
    nrdv = 0;
    got_d = '0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (sn_rdv) begin
        nrdv++;
        got_d = sn_data;
      end
    end
    check("t6_rdv_cnt", nrdv, 1);
    check("t6_data", got_d, sdat(1, 32'h100));

    // random traffic
    rnd_lat = 1;
    pend = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!pend) begin
        r = $urandom_range(0, 9);
        bus.read = (r < 6);
        bus.write = (r >= 6 && r < 8);
        bus.writedata = 16'($urandom);
        if ($urandom_range(0, 4) < 4)
          bus.address = base[$urandom_range(0, N-1)] +
                        $urandom_range(0, 32'hFFF);
        else
          bus.address = $urandom_range(32'h4000, 32'hFFFF);
      end
      for (int i = 0; i < N; i++)
        s_wait[i] = ($urandom_range(0, 3) == 0);
      step();
      pend = (bus.read || bus.write) && !last_acc;
    end
    s_wait = '0;
    drain("rnd_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
